seq_step_ctrl: RTL

//  Run/step controller for the 8-code cyclic sequence 000,011,010,101,001,110,100,111 (then back to 000).

---
 rtl/seq_pkg.sv | 41 ++++
 rtl/seq_code_rom.sv | 26 ++
 rtl/seq_step_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 8-code step sequencer: state encoding, code table,
// index stepping helpers and the registered status bundle.
package seq_pkg;

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned ST_W    = 2;
  localparam int unsigned SEQ_LEN = 8;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_HOLD = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  localparam logic [IDX_W-1:0] IDX_FIRST = 3'd0;
  localparam logic [IDX_W-1:0] IDX_LAST  = 3'd7;

  // Entry i is the code presented while the index register holds i.
  localparam logic [SEQ_LEN-1:0][CODE_W-1:0] SEQ_TBL = {
    3'b111, 3'b100, 3'b110, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000
  };

  typedef struct packed {
    logic code_valid;
    logic busy;
    logic done;
    logic wrap;
  } seq_status_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic             dir);
    return dir ? IDX_W'(idx - IDX_W'(1)) : IDX_W'(idx + IDX_W'(1));
  endfunction

  // True when stepping from idx in direction dir crosses the 7/0 boundary.
  function automatic logic is_wrap(input logic [IDX_W-1:0] idx,
                                   input logic             dir);
    return dir ? (idx == IDX_FIRST) : (idx == IDX_LAST);
  endfunction

endpackage

// File: rtl/seq_code_rom.sv
// Registered index-to-code lookup; fed with the next index so the output
// always matches the index register one cycle later.
module seq_code_rom
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_d,
  output logic [CODE_W-1:0] code_q
);

  logic [CODE_W-1:0] code_d;

  always_comb begin
    code_d = SEQ_TBL[idx_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

endmodule

// File: rtl/seq_step_ctrl.sv
// Run/step controller for the cyclic 8-code sequence: dwell counter, index
// register and valid/ready delivery of each code to the downstream consumer.
module seq_step_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              mode,
  input  logic              dir,
  input  logic [CNT_W-1:0]  dwell,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  seq_status_t      stat_q, stat_d;

  logic [CNT_W-1:0] reload_c;
  logic             xfer_c;
  logic             wrap_c;

  // A dwell of zero is treated as one cycle.
  assign reload_c = (dwell == '0) ? '0 : CNT_W'(dwell - CNT_W'(1));
  assign xfer_c   = stat_q.code_valid & code_ready;
  assign wrap_c   = is_wrap(idx_q, dir);

  always_comb begin : fsm_comb
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    stat_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          cnt_d   = reload_c;
        end else if (step) begin
          state_d  = ST_HOLD;
          single_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end

      ST_HOLD: begin
        // stop abandons the offered code; idx is kept so a later start resumes here
        if (stop) begin
          state_d  = ST_IDLE;
          single_d = 1'b0;
        end else if (xfer_c) begin
          idx_d       = next_idx(idx_q, dir);
          stat_d.wrap = wrap_c;
          if (single_q) begin
            state_d  = ST_IDLE;
            single_d = 1'b0;
          end else if (mode && wrap_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            cnt_d   = reload_c;
          end
        end
      end

      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          idx_d   = dir ? IDX_LAST : IDX_FIRST;
          cnt_d   = reload_c;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        single_d = 1'b0;
      end
    endcase

    stat_d.code_valid = (state_d == ST_HOLD);
    stat_d.busy       = (state_d == ST_RUN) || (state_d == ST_HOLD);
    stat_d.done       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_FIRST;
      cnt_q    <= '0;
      single_q <= 1'b0;
      stat_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      stat_q   <= stat_d;
    end
  end

  seq_code_rom u_rom (
    .clk    (clk),
    .rst    (rst),
    .idx_d  (idx_d),
    .code_q (code_out)
  );

  assign code_valid = stat_q.code_valid;
  assign busy       = stat_q.busy;
  assign done       = stat_q.done;
  assign wrap       = stat_q.wrap;

endmodule
